fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one FIFO write port with bursts of up to BURST_LEN words.
// Define FIFO_ARB_STATS_EN to add the per-requester accepted-word counters on word_cnt.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     full_flag,
  output logic                     wr_en,
  output logic [WIDTH-1:0]         wr_data,
  output logic [2:0]               grant_id,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    word_cnt
`endif
);

  typedef enum logic {StIdle, StBurst} state_e;

  localparam logic [2:0] LastInit = 3'(NUM_REQ - 1);
  localparam logic [3:0] CntLast  = 4'(BURST_LEN - 1);

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] grant_data;
  logic             grant_valid;
  logic [2:0]       pick;
  logic             pick_found;

  // Granted requester's word and valid.
  always_comb begin
    grant_data  = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        grant_data  = req_data[i*WIDTH +: WIDTH];
        grant_valid = req_valid[i];
      end
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned idx;
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick       = 3'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // Reset gates the outputs so nothing is accepted in the reset cycle.
  always_comb begin
    busy     = (state_q == StBurst) && !wr_rst;
    wr_en    = busy && grant_valid && !full_flag;
    wr_data  = busy ? grant_data : data_q;
    grant_id = grant_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy && !full_flag && (grant_q == 3'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StBurst;
          grant_d = pick;
        end
      end
      StBurst: begin
        // A full FIFO freezes the burst indefinitely.
        if (!full_flag) begin
          if (!grant_valid || cnt_q == CntLast) begin
            state_d = StIdle;
            last_d  = grant_q;
            grant_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= LastInit;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (state_q == StBurst) begin
        data_q <= grant_data;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat_q;

  always_ff @(posedge wr_clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_rst) begin
        stat_q[i] <= '0;
      end else if (wr_en && grant_q == 3'(i) && stat_q[i] != 16'hFFFF) begin
        stat_q[i] <= stat_q[i] + 16'd1;
      end
    end
  end

  assign word_cnt = stat_q;
`endif

endmodule
